// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID instruction queue: NOP encoding,
// default datapath width and the queue-entry layout.
package if_id_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [XLEN_DEFAULT-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] inst;
    logic [XLEN_DEFAULT-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry storage for the IF/ID queue: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module ifq_storage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store the offered entry at the tail slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/if_id_inst_queue.sv
// IF/ID decoupling queue between fetch and decode. Defining IFQ_BYPASS_EN
// adds a zero-latency path from fetch to decode when the queue is empty.
module if_id_inst_queue
  import if_id_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [XLEN-1:0]          fetch_inst,
  input  logic [XLEN-1:0]          fetch_pc,
  output logic                     fetch_ready,
  input  logic                     bubbleD,
  input  logic                     flushD,
  output logic [XLEN-1:0]          inst_ID,
  output logic [XLEN-1:0]          pc_ID,
  output logic                     valid_ID,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     head_r;
  logic [AW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic [2*XLEN-1:0] head_data_s;
  logic [XLEN-1:0]   head_inst_s;
  logic [XLEN-1:0]   head_pc_s;
  logic              empty_s;
  logic              full_s;
  logic              bypass_s;
  logic              push_s;
  logic              pop_s;

  assign empty_s = (count_r == CW'(0));
  assign full_s  = (count_r == CW'(DEPTH));

`ifdef IFQ_BYPASS_EN
  assign bypass_s = empty_s & fetch_valid & ~flushD;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed instruction that decode takes immediately is never written.
  assign push_s = fetch_valid & ~full_s & ~flushD & ~(bypass_s & ~bubbleD);
  assign pop_s  = ~empty_s & ~bubbleD & ~flushD;

  assign fetch_ready = ~full_s;
  assign count       = count_r;

  ifq_storage #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push_s),
    .waddr (tail_r),
    .wdata ({fetch_inst, fetch_pc}),
    .raddr (head_r),
    .rdata (head_data_s)
  );

  assign {head_inst_s, head_pc_s} = head_data_s;

  // Pointer and occupancy tracking; a flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= AW'(0);
      tail_r  <= AW'(0);
      count_r <= CW'(0);
    end else if (flushD) begin
      head_r  <= AW'(0);
      tail_r  <= AW'(0);
      count_r <= CW'(0);
    end else begin
      if (push_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Decode-side view: bypass, head entry, or a NOP when nothing is available.
  always_comb begin
    inst_ID  = XLEN'(NOP_INST);
    pc_ID    = {XLEN{1'b0}};
    valid_ID = 1'b0;
    if (bypass_s) begin
      inst_ID  = fetch_inst;
      pc_ID    = fetch_pc;
      valid_ID = 1'b1;
    end else if (!empty_s) begin
      inst_ID  = head_inst_s;
      pc_ID    = head_pc_s;
      valid_ID = 1'b1;
    end else begin
      inst_ID  = XLEN'(NOP_INST);
      pc_ID    = {XLEN{1'b0}};
      valid_ID = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Scoreboard bench for if_id_inst_queue: directed scenarios followed by
// randomized fetch/stall/flush/reset traffic against a queue-based model.
module tb_if_id_inst_queue;
  import if_id_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_inst;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ready;
  logic            bubbleD;
  logic            flushD;
  logic [XLEN-1:0] inst_ID;
  logic [XLEN-1:0] pc_ID;
  logic            valid_ID;
  logic [CW-1:0]   count;

  int tests_run = 0;
  int tests_failed = 0;
  bit running = 1'b1;

  ifq_entry_t exp_q[$];

  if_id_inst_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .bubbleD     (bubbleD),
    .flushD      (flushD),
    .inst_ID     (inst_ID),
    .pc_ID       (pc_ID),
    .valid_ID    (valid_ID),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bypass_active();
`ifdef IFQ_BYPASS_EN
    return (exp_q.size() == 0) && fetch_valid && !flushD && rst_n;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: mid-cycle, compare the decode view against the model, then retire.
  always begin
    @(posedge clk);
    #7;
    if (running) begin
      if (!rst_n) begin
        exp_q.delete();
        check("rst_valid", 64'(valid_ID), 64'd0);
        check("rst_inst", 64'(inst_ID), 64'd0);
        check("rst_pc", 64'(pc_ID), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(fetch_ready), 64'd1);
      end else begin
        check("count", 64'(count), 64'(exp_q.size()));
        check("fetch_ready", 64'(fetch_ready), 64'(exp_q.size() < DEPTH));
        if (bypass_active()) begin
          check("byp_valid", 64'(valid_ID), 64'd1);
          check("byp_inst", 64'(inst_ID), 64'(fetch_inst));
          check("byp_pc", 64'(pc_ID), 64'(fetch_pc));
        end else if (exp_q.size() != 0) begin
          check("valid", 64'(valid_ID), 64'd1);
          check("inst", 64'(inst_ID), 64'(exp_q[0].inst));
          check("pc", 64'(pc_ID), 64'(exp_q[0].pc));
        end else begin
          check("empty_valid", 64'(valid_ID), 64'd0);
          check("empty_inst", 64'(inst_ID), 64'd0);
          check("empty_pc", 64'(pc_ID), 64'd0);
        end
        if (flushD) begin
          exp_q.delete();
        end else if (exp_q.size() != 0 && !bubbleD) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drive one cycle of stimulus; the accepted offer enters the scoreboard
  // after the monitor has looked at the current cycle.
  task automatic drive(input logic rst, input logic fv, input logic [XLEN-1:0] inst,
                       input logic [XLEN-1:0] pc, input logic bub, input logic fl);
    bit accept;
    ifq_entry_t e;
    @(posedge clk);
    #2;
    rst_n       = rst;
    fetch_valid = fv;
    fetch_inst  = inst;
    fetch_pc    = pc;
    bubbleD     = bub;
    flushD      = fl;
    accept = rst && fv && !fl && (exp_q.size() < DEPTH);
`ifdef IFQ_BYPASS_EN
    if (exp_q.size() == 0 && !bub) accept = 1'b0;
`endif
    e.inst = inst;
    e.pc   = pc;
    #6;
    if (accept) exp_q.push_back(e);
  endtask

  task automatic idle(input logic bub);
    drive(1'b1, 1'b0, 32'h0, 32'h0, bub, 1'b0);
  endtask

  initial begin
    logic [XLEN-1:0] pc_v;
    rst_n = 1'b0;
    fetch_valid = 1'b0;
    fetch_inst = '0;
    fetch_pc = '0;
    bubbleD = 1'b0;
    flushD = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Single instruction, first edge after reset release.
    drive(1'b1, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Fill under stall, hold, then drain and wrap the tail.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'hDEAD, 32'h10, 1'b1, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 4; i++) idle(1'b0);
    drive(1'b1, 1'b1, 32'h2000, 32'h20, 1'b1, 1'b0);
    idle(1'b0);

    // Three entries, then flush together with a push.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'h3000 + 32'(i), 32'h40 + 32'(i * 4), 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h3FFF, 32'h60, 1'b1, 1'b1);
    idle(1'b0);

    // Reset with two entries held.
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 32'h4000 + 32'(i), 32'h80 + 32'(i * 4), 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1'b0);

    // Empty-queue offer consumed immediately.
    drive(1'b1, 1'b1, 32'h00A00113, 32'h100, 1'b0, 1'b0);
    idle(1'b0);

    // Randomized traffic.
    pc_v = 32'h200;
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(9) < 7), $urandom, pc_v,
            ($urandom_range(9) < 4), ($urandom_range(19) == 0));
      pc_v = pc_v + 32'd4;
    end
    idle(1'b0);

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_id_inst_queue.md
IF_ID_INST_QUEUE -- requirements
Module: if_id_inst_queue

Interface
REQ-001 Parameter XLEN, default 32: instruction and PC width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_valid  input  1  fetch stage offers an instruction this cycle.
REQ-006 fetch_inst  input  XLEN  offered instruction word.
REQ-007 fetch_pc  input  XLEN  PC of the offered instruction.
REQ-008 fetch_ready  output  1  queue accepts an offer this cycle.
REQ-009 bubbleD  input  1  decode stall; holds the head entry.
REQ-010 flushD  input  1  discard every queued and offered instruction.
REQ-011 inst_ID  output  XLEN  head instruction to decode.
REQ-012 pc_ID  output  XLEN  PC of the head instruction.
REQ-013 valid_ID  output  1  inst_ID/pc_ID hold a real instruction.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Push when fetch_valid and fetch_ready and not flushD: write {fetch_inst, fetch_pc} at the tail and advance the tail pointer.
REQ-016 fetch_ready SHALL be 1 exactly when count < DEPTH; a simultaneous pop does not raise fetch_ready when the queue is full.
REQ-017 Pop when valid_ID and not bubbleD and not flushD: advance the head pointer.
REQ-018 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL distinguish full (DEPTH) from empty (0).
REQ-020 When non-empty, the outputs SHALL drive the head entry: inst_ID and pc_ID equal the head entry, and valid_ID = 1.
REQ-021 When empty and no bypass applies, the outputs SHALL be: inst_ID = NOP_INST (all zeros), pc_ID = 0, valid_ID = 0.
REQ-022 While bubbleD = 1, inst_ID, pc_ID and valid_ID SHALL stay constant cycle to cycle, unless a push fills an empty queue.
REQ-023 flushD = 1 at an edge SHALL set count to 0, reset both pointers, and discard any same-cycle push.
REQ-024 After a flush, the next cycle SHALL show valid_ID = 0 and inst_ID = 0.
REQ-025 flushD SHALL take priority over bubbleD.
REQ-026 An offered instruction SHALL take at least one cycle to appear at the outputs (no bypass without the macro).

Reset
REQ-027 Asserting rst_n low SHALL immediately clear the pointers and count, and force valid_ID = 0, inst_ID = 0, pc_ID = 0 and fetch_ready = 1.
REQ-028 Deassertion SHALL be usable synchronously; the first push is accepted on the first edge with rst_n high.
REQ-029 Reset mid-operation SHALL discard all entries without emitting any partial entry.
REQ-030 Storage contents need not be reset.

Configuration
REQ-031 Macro IFQ_BYPASS_EN, when defined, enables a zero-latency bypass: if count = 0, fetch_valid = 1 and flushD = 0, the outputs drive fetch_inst/fetch_pc with valid_ID = 1 in the same cycle.
REQ-032 Under the bypass, if bubbleD = 0 the instruction is consumed without being written; if bubbleD = 1 it is pushed normally.
REQ-033 Without IFQ_BYPASS_EN, REQ-026 holds and the outputs depend only on registered state.

Structure
REQ-034 Shared package if_id_pkg SHALL hold NOP_INST, the default XLEN, and the queue-entry struct {inst, pc}.
REQ-035 Storage SHALL be the sub-module ifq_storage: DEPTH x 2*XLEN array with one write port and one asynchronous read port.
REQ-036 Pointer, count and output control SHALL live in if_id_inst_queue.

Verification
REQ-037 Reset, then push 0x00500093 @pc 0x0 with bubbleD = 0 -> next cycle valid_ID = 1, inst_ID = 0x00500093, pc_ID = 0; following cycle valid_ID = 0 (no bypass).
REQ-038 bubbleD = 1, push 4 entries (pc 0x0, 0x4, 0x8, 0xC) -> count = 4, fetch_ready = 0, and the head stays at pc 0x0.
REQ-039 Then drop bubbleD -> pcs 0x0, 0x4, 0x8, 0xC emerge on consecutive cycles, and the tail wraps on the next push.
REQ-040 Queue holding 3 entries, flushD = 1 together with a push -> next cycle count = 0, valid_ID = 0, inst_ID = 0.
REQ-041 Assert rst_n low mid-stream with count = 2 -> outputs clear immediately; after release, fetch_ready = 1 and count = 0.
REQ-042 With IFQ_BYPASS_EN, empty queue, push 0x00A00113 with bubbleD = 0 -> same cycle valid_ID = 1, inst_ID = 0x00A00113, and count stays 0.
